// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: shift-register scoreboard of in-flight GPR writes with per-entry
// result latency, producing the ID stall, rs/rt bypass selects and the HI/LO interlock.
module hazard_scoreboard #(
  parameter int NSTAGE  = 3,
  parameter int MAX_LAT = 3,
  parameter int MD_LAT  = 8,
  parameter int SELW    = $clog2(NSTAGE + 1)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           id_valid,
  input  logic [4:0]                     id_rs,
  input  logic [4:0]                     id_rt,
  input  logic                           id_use_rs,
  input  logic                           id_use_rt,
  input  logic                           id_early,
  input  logic                           id_reg_write,
  input  logic [4:0]                     id_rw,
  input  logic [$clog2(MAX_LAT+1)-1:0]   id_lat,
  input  logic                           id_md_start,
  input  logic                           id_use_hilo,
  input  logic                           flush_id,
  input  logic                           flush_all,
  output logic                           stall,
  output logic [SELW-1:0]                fwd_rs_sel,
  output logic [SELW-1:0]                fwd_rt_sel,
  output logic                           md_busy
);

  localparam int REMW = $clog2(MAX_LAT + 1);
  localparam int MDW  = $clog2(MD_LAT + 1);

  typedef struct packed {
    logic            v;
    logic [4:0]      rw;
    logic [REMW-1:0] rem;
  } entry_t;

  entry_t          sb_q [NSTAGE];
  entry_t          sb_d [NSTAGE];
  logic [MDW-1:0]  md_cnt_q, md_cnt_d;

  logic            gpr_hazard;
  logic            md_hazard;
  logic            stall_raw;
  logic [SELW-1:0] rs_sel, rt_sel;
  logic [REMW-1:0] lat_sat;
  logic            insert;
  logic            md_load;

  // Hazard detection and bypass selection, all from pre-shift state.
  always_comb begin
    gpr_hazard = 1'b0;
    rs_sel     = '0;
    rt_sel     = '0;
    // Walk oldest to youngest so the youngest ready match wins the select.
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      if (sb_q[i].v && id_use_rs && id_rs != 5'd0 && sb_q[i].rw == id_rs) begin
        if (id_early ? (sb_q[i].rem != '0) : (sb_q[i].rem > REMW'(1))) gpr_hazard = 1'b1;
        if (sb_q[i].rem == '0) rs_sel = SELW'(i + 1);
      end
      if (sb_q[i].v && id_use_rt && id_rt != 5'd0 && sb_q[i].rw == id_rt) begin
        if (id_early ? (sb_q[i].rem != '0) : (sb_q[i].rem > REMW'(1))) gpr_hazard = 1'b1;
        if (sb_q[i].rem == '0) rt_sel = SELW'(i + 1);
      end
    end
  end

  assign md_hazard = (id_use_hilo || id_md_start) && (md_cnt_q != '0);
  assign stall_raw = id_valid && (gpr_hazard || md_hazard);

  // Outputs are held at their idle values while reset is asserted.
  always_comb begin
    stall      = 1'b0;
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    md_busy    = 1'b0;
    if (!reset) begin
      stall      = stall_raw;
      fwd_rs_sel = rs_sel;
      fwd_rt_sel = rt_sel;
      md_busy    = (md_cnt_q != '0);
    end
  end

  always_comb begin
    lat_sat = id_lat;
    if (int'(id_lat) > MAX_LAT) lat_sat = REMW'(MAX_LAT);
  end

  assign insert  = id_valid && !stall_raw && !flush_id && id_reg_write && (id_rw != 5'd0);
  assign md_load = id_valid && id_md_start && !stall_raw && !flush_id;

  always_comb begin
    for (int i = 0; i < NSTAGE; i++) sb_d[i] = '0;
    for (int i = 1; i < NSTAGE; i++) begin
      sb_d[i] = sb_q[i-1];
      if (sb_q[i-1].rem != '0) sb_d[i].rem = sb_q[i-1].rem - REMW'(1);
    end
    if (insert) begin
      sb_d[0].v   = 1'b1;
      sb_d[0].rw  = id_rw;
      sb_d[0].rem = lat_sat;
    end

    md_cnt_d = md_cnt_q;
    if (md_load) begin
      md_cnt_d = MDW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MDW'(1);
    end

    if (flush_all) begin
      for (int i = 0; i < NSTAGE; i++) sb_d[i].v = 1'b0;
      md_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= '0;
      md_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NSTAGE; i++) sb_q[i] <= sb_d[i];
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues the expected outputs for each
// cycle it drives, and an independent monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use_rs, id_use_rt, id_early, id_reg_write;
  logic [4:0] id_rs, id_rt, id_rw;
  logic [1:0] id_lat;
  logic       id_md_start, id_use_hilo, flush_id, flush_all;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  typedef struct {
    string      nm;
    logic       stall;
    logic [1:0] rs;
    logic [1:0] rt;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_early     (id_early),
    .id_reg_write (id_reg_write),
    .id_rw        (id_rw),
    .id_lat       (id_lat),
    .id_md_start  (id_md_start),
    .id_use_hilo  (id_use_hilo),
    .flush_id     (flush_id),
    .flush_all    (flush_all),
    .stall        (stall),
    .fwd_rs_sel   (fwd_rs_sel),
    .fwd_rt_sel   (fwd_rt_sel),
    .md_busy      (md_busy)
  );

  // Monitor: outputs are combinational and valid every cycle once inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (stall !== e.stall || fwd_rs_sel !== e.rs || fwd_rt_sel !== e.rt ||
            md_busy !== e.busy) begin
          n_err++;
          $display("FAIL %s: got stall=%b rs=%0d rt=%0d busy=%b, want stall=%b rs=%0d rt=%0d busy=%b",
                   e.nm, stall, fwd_rs_sel, fwd_rt_sel, md_busy,
                   e.stall, e.rs, e.rt, e.busy);
        end
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_early = 0;
    id_reg_write = 0; id_rw = 0; id_lat = 0; id_md_start = 0; id_use_hilo = 0;
    flush_id = 0; flush_all = 0;
  endtask

  task automatic wr(input logic [4:0] rw, input logic [1:0] lat);
    id_valid = 1; id_reg_write = 1; id_rw = rw; id_lat = lat;
  endtask

  task automatic rd_rs(input logic [4:0] r, input logic early);
    id_valid = 1; id_use_rs = 1; id_rs = r; id_early = early;
  endtask

  task automatic rd_rt(input logic [4:0] r, input logic early);
    id_valid = 1; id_use_rt = 1; id_rt = r; id_early = early;
  endtask

  // Queue the expectation for the inputs currently driven, then advance one cycle.
  task automatic cyc(input string nm, input logic es, input logic [1:0] ers,
                     input logic [1:0] ert, input logic eb);
    exp_t e;
    e.nm = nm; e.stall = es; e.rs = ers; e.rt = ert; e.busy = eb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1;
    @(posedge clk);
    #1;

    // Reset: outputs idle even with hazardous-looking inputs.
    id_valid = 1; id_md_start = 1; id_use_hilo = 1; rd_rs(5'd5, 1);
    cyc("reset_hold", 0, 0, 0, 0);
    cyc("reset_hold2", 0, 0, 0, 0);
    reset = 0;
    rd_rs(5'd5, 1); rd_rt(5'd8, 1); id_use_hilo = 1;
    cyc("after_reset", 0, 0, 0, 0);

    // ALU r5, lat 1.
    wr(5'd5, 1);     cyc("alu_wr", 0, 0, 0, 0);
    rd_rs(5'd5, 0);  cyc("alu_use_ex", 0, 0, 0, 0);
    rd_rs(5'd5, 0);  cyc("alu_fwd_mem", 0, 2, 0, 0);
    id_use_rs = 1; id_rs = 5'd5;
                     cyc("alu_fwd_wb_novalid", 0, 3, 0, 0);
    rd_rs(5'd5, 0);  cyc("alu_gone", 0, 0, 0, 0);

    // Load r8, lat 2, normal use on rt.
    wr(5'd8, 2);     cyc("ld_wr", 0, 0, 0, 0);
    rd_rt(5'd8, 0);  cyc("ld_use_stall", 1, 0, 0, 0);
    rd_rt(5'd8, 0);  cyc("ld_use_release", 0, 0, 0, 0);
    rd_rt(5'd8, 0);  cyc("ld_fwd_wb", 0, 0, 3, 0);
    cyc("ld_gone", 0, 0, 0, 0);

    // ALU r3 then branch on r3.
    wr(5'd3, 1);     cyc("br_alu_wr", 0, 0, 0, 0);
    rd_rs(5'd3, 1);  cyc("br_ex_stall", 1, 0, 0, 0);
    rd_rs(5'd3, 1);  cyc("br_ex_fwd", 0, 2, 0, 0);
    cyc("br_idle", 0, 0, 0, 0);

    // Load r7 then branch on r7: two stall cycles.
    wr(5'd7, 2);     cyc("brld_wr", 0, 0, 0, 0);
    rd_rs(5'd7, 1);  cyc("brld_stall1", 1, 0, 0, 0);
    rd_rs(5'd7, 1);  cyc("brld_stall2", 1, 0, 0, 0);
    rd_rs(5'd7, 1);  cyc("brld_fwd", 0, 3, 0, 0);

    // r0 never tracked; unused sources never match.
    wr(5'd0, 2);     cyc("r0_wr", 0, 0, 0, 0);
    rd_rs(5'd0, 1); rd_rt(5'd0, 1);
                     cyc("r0_use", 0, 0, 0, 0);
    wr(5'd6, 2);     cyc("nouse_wr", 0, 0, 0, 0);
    id_valid = 1; id_rs = 5'd6; id_rt = 5'd6; id_early = 1;
                     cyc("nouse_ex", 0, 0, 0, 0);
    id_valid = 1; id_rs = 5'd6; id_rt = 5'd6; id_early = 1;
                     cyc("nouse_mem", 0, 0, 0, 0);
    id_valid = 1; id_rs = 5'd6; id_rt = 5'd6;
                     cyc("nouse_wb", 0, 0, 0, 0);

    // flush_id and a stalled ID both suppress insertion.
    wr(5'd4, 1); flush_id = 1;
                     cyc("flushid_wr", 0, 0, 0, 0);
    rd_rs(5'd4, 1);  cyc("flushid_use", 0, 0, 0, 0);
    wr(5'd10, 2);    cyc("stallins_ld", 0, 0, 0, 0);
    wr(5'd11, 1); rd_rs(5'd10, 0);
                     cyc("stallins_stall", 1, 0, 0, 0);
    rd_rs(5'd11, 1); cyc("stallins_noentry", 0, 0, 0, 0);
    cyc("stallins_idle", 0, 0, 0, 0);

    // Back-to-back writes to r9: youngest ready entry wins.
    wr(5'd9, 1);     cyc("yng_wr1", 0, 0, 0, 0);
    wr(5'd9, 1);     cyc("yng_wr2", 0, 0, 0, 0);
    rd_rs(5'd9, 0);  cyc("yng_use1", 0, 2, 0, 0);
    rd_rs(5'd9, 0); rd_rt(5'd9, 0);
                     cyc("yng_use2", 0, 2, 2, 0);
    rd_rt(5'd9, 0);  cyc("yng_last", 0, 0, 3, 0);

    // Latency 0: forwardable straight out of EX, even to a branch.
    wr(5'd12, 0);    cyc("lat0_wr", 0, 0, 0, 0);
    rd_rs(5'd12, 1); cyc("lat0_use", 0, 1, 0, 0);
    cyc("lat0_idle1", 0, 0, 0, 0);
    cyc("lat0_idle2", 0, 0, 0, 0);

    // MD unit: mfhi waits out MD_LAT cycles.
    id_valid = 1; id_md_start = 1;
                     cyc("md_start", 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      id_valid = 1; id_use_hilo = 1;
      cyc($sformatf("md_wait%0d", k), 1, 0, 0, 1);
    end
    id_valid = 1; id_use_hilo = 1;
                     cyc("md_release", 0, 0, 0, 0);

    // MD flushed mid-count.
    id_valid = 1; id_md_start = 1;
                     cyc("mdf_start", 0, 0, 0, 0);
    id_valid = 1; id_use_hilo = 1;
                     cyc("mdf_wait1", 1, 0, 0, 1);
    id_valid = 1; id_use_hilo = 1;
                     cyc("mdf_wait2", 1, 0, 0, 1);
    id_valid = 1; id_use_hilo = 1; flush_all = 1;
                     cyc("mdf_flush", 1, 0, 0, 1);
    id_valid = 1; id_use_hilo = 1;
                     cyc("mdf_after", 0, 0, 0, 0);

    // flush_all clears GPR entries too.
    wr(5'd13, 2);    cyc("fa_wr", 0, 0, 0, 0);
    rd_rs(5'd13, 0); flush_all = 1;
                     cyc("fa_flush", 1, 0, 0, 0);
    rd_rs(5'd13, 1); cyc("fa_after", 0, 0, 0, 0);

    // Reset mid-operation.
    wr(5'd15, 2);    cyc("rst_wr", 0, 0, 0, 0);
    reset = 1; rd_rs(5'd15, 1);
                     cyc("rst_hold", 0, 0, 0, 0);
    reset = 0; rd_rs(5'd15, 1);
                     cyc("rst_after", 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
